// File: rtl/kgp_pkg.sv
// Shared opcode constants, sequencer state encoding and defaults for the
// KGP-RISC program-counter / fetch sequencer.
package kgp_pkg;

  localparam logic [5:0] OP_BLTZ = 6'b001000;
  localparam logic [5:0] OP_BZ   = 6'b001001;
  localparam logic [5:0] OP_BNZ  = 6'b001010;
  localparam logic [5:0] OP_BR   = 6'b001011;
  localparam logic [5:0] OP_B    = 6'b001100;
  localparam logic [5:0] OP_BL   = 6'b001101;
  localparam logic [5:0] OP_BCY  = 6'b001110;
  localparam logic [5:0] OP_BNCY = 6'b001111;

  localparam logic [31:0] PC_STEP_DEFAULT  = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  // The whole 001xxx block is the branch family.
  function automatic logic is_jump_op(input logic [5:0] op);
    return op[5:3] == 3'b001;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch handshake, execute-completion inputs and architectural outputs of
// the PC sequencer, bundled for the sequencer (master) and core (slave).
interface pc_sequencer_if;

  // fetch_req/fetch_ack: fetch_req acts as valid and holds fetch_addr stable
  // until a cycle where fetch_ack is high; a fetch_ack seen while fetch_req
  // is low is ignored. exec_done is a one-cycle pulse qualifying the
  // opcode/valid_jump/offset/reg_target/halt_req bundle.
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ack;

  logic        exec_done;
  logic [5:0]  opcode;
  logic        valid_jump;
  logic [31:0] offset;
  logic [31:0] reg_target;
  logic        halt_req;

  logic [31:0] pc;
  logic        link_we;
  logic [31:0] link_addr;
  logic [31:0] instret;
  logic        halted;
  logic        fault;

  modport master (
    output fetch_req, fetch_addr, pc, link_we, link_addr, instret, halted, fault,
    input  fetch_ack, exec_done, opcode, valid_jump, offset, reg_target, halt_req
  );

  modport slave (
    input  fetch_req, fetch_addr, pc, link_we, link_addr, instret, halted, fault,
    output fetch_ack, exec_done, opcode, valid_jump, offset, reg_target, halt_req
  );

endinterface

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential, PC-relative branch, or
// register-indirect br, plus the alignment check on the chosen target.
module next_pc_calc
  import kgp_pkg::*;
#(
  parameter logic [31:0] PC_STEP = PC_STEP_DEFAULT
) (
  input  logic [31:0] pc,
  input  logic [5:0]  opcode,
  input  logic        valid_jump,
  input  logic [31:0] offset,
  input  logic [31:0] reg_target,
  output logic [31:0] target,
  output logic [31:0] pc4,
  output logic        misaligned
);

  assign pc4 = pc + PC_STEP;

  // br always jumps to rs; the other branch opcodes trust valid_jump.
  always_comb begin
    target = pc4;
    if (opcode == OP_BR) begin
      target = reg_target;
    end else if (is_jump_op(opcode) && valid_jump) begin
      target = pc4 + (offset << 2);
    end
  end

  assign misaligned = |target[1:0];

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter and fetch sequencer: fetch handshake, next-PC commit,
// bl link write, retired-instruction counter, halt and fault latching.
module pc_sequencer
  import kgp_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  pc_sequencer_if.master    bus,
  output state_t            dbg_state
);

  state_t      state;
  state_t      state_nxt;
  logic        started;
  logic        fetch_req;
  logic        fetch_fire;
  logic        done_in_exec;
  logic        commit;
  logic        take_fault;
  logic        is_bl;

  logic [31:0] pc_r;
  logic [31:0] instret_r;
  logic [31:0] link_addr_r;
  logic        link_we_r;

  logic [31:0] target;
  logic [31:0] pc4;
  logic        misaligned;

  next_pc_calc #(.PC_STEP(PC_STEP)) u_next_pc_calc (
    .pc         (pc_r),
    .opcode     (bus.opcode),
    .valid_jump (bus.valid_jump),
    .offset     (bus.offset),
    .reg_target (bus.reg_target),
    .target     (target),
    .pc4        (pc4),
    .misaligned (misaligned)
  );

  assign fetch_fire   = fetch_req && bus.fetch_ack;
  assign done_in_exec = (state == ST_EXEC) && bus.exec_done;
  assign commit       = done_in_exec && !misaligned;
  assign take_fault   = done_in_exec && misaligned;
  assign is_bl        = bus.opcode == OP_BL;

  // started keeps fetch_req low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_FETCH;
      started <= 1'b0;
    end else begin
      state   <= state_nxt;
      started <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_FETCH: if (fetch_fire) state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (take_fault) begin
          state_nxt = ST_FAULT;
        end else if (commit) begin
          state_nxt = bus.halt_req ? ST_HALT : ST_FETCH;
        end
      end
      default: state_nxt = state;
    endcase
  end

  always_comb begin
    fetch_req  = (state == ST_FETCH) && started;
    bus.halted = state == ST_HALT;
    bus.fault  = state == ST_FAULT;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_r        <= RESET_PC;
      instret_r   <= 32'd0;
      link_we_r   <= 1'b0;
      link_addr_r <= 32'd0;
    end else begin
      link_we_r <= commit && is_bl;
      if (commit) begin
        pc_r      <= target;
        instret_r <= instret_r + 32'd1;
        if (is_bl) link_addr_r <= pc4;
      end
    end
  end

  assign bus.fetch_req  = fetch_req;
  assign bus.fetch_addr = pc_r;
  assign bus.pc         = pc_r;
  assign bus.instret    = instret_r;
  assign bus.link_we    = link_we_r;
  assign bus.link_addr  = link_addr_r;
  assign dbg_state      = state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Table-driven bench for pc_sequencer with an expected-fetch-address queue
// and hand-written halt, fault and reset sequences.
module tb_pc_sequencer;
  import kgp_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic   clk = 1'b0;
  logic   rst;
  state_t dbg_state;

  pc_sequencer_if bus ();

  pc_sequencer #(.RESET_PC(RST_PC), .PC_STEP(32'd4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  opcode;
    logic        vj;
    logic [31:0] offset;
    logic [31:0] reg_target;
    int          wait_cyc;
    logic        stray_done;
    logic        stray_halt;
    logic        halt;
    logic [31:0] exp_pc;
    logic        exp_lw;
    logic [31:0] exp_la;
    logic        exp_fault;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          exp_instret = 0;
  int          cyc = 0;
  int          last_fetch_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic vec_t mk(input logic [5:0] op, input logic vj, input logic [31:0] off,
                              input logic [31:0] rt, input int w, input logic sd, input logic sh,
                              input logic h, input logic [31:0] epc, input logic elw,
                              input logic [31:0] ela, input logic ef);
    vec_t v;
    v.opcode = op; v.vj = vj; v.offset = off; v.reg_target = rt; v.wait_cyc = w;
    v.stray_done = sd; v.stray_halt = sh; v.halt = h;
    v.exp_pc = epc; v.exp_lw = elw; v.exp_la = ela; v.exp_fault = ef;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic async_reset();
    rst = 1'b0;
    #1;
    check("rst_pc", bus.pc, RST_PC);
    check("rst_instret", bus.instret, 32'd0);
    check("rst_link_we", bus.link_we, 1'b0);
    check("rst_link_addr", bus.link_addr, 32'd0);
    check("rst_halted", bus.halted, 1'b0);
    check("rst_fault", bus.fault, 1'b0);
    check("rst_fetch_req", bus.fetch_req, 1'b0);
    check("rst_state", dbg_state, ST_FETCH);
    bus.fetch_ack = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("req_low_after_release", bus.fetch_req, 1'b0);
    tick();
    check("stale_ack_ignored", dbg_state, ST_FETCH);
    check("req_first_edge", bus.fetch_req, 1'b1);
    bus.fetch_ack = 1'b0;
    exp_q.delete();
    exp_q.push_back(RST_PC);
    exp_instret = 0;
    last_fetch_cyc = cyc;
  endtask

  task automatic fetch_phase(input int wait_cyc, input logic stray_done, input logic measure);
    int          guard;
    logic [31:0] e;
    logic [31:0] addr0;
    logic [31:0] pc0;
    guard = 0;
    while (!bus.fetch_req && guard < 20) begin
      tick();
      guard++;
    end
    check("fetch_req_seen", bus.fetch_req, 1'b1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check("fetch_addr", bus.fetch_addr, e);
    if (measure) check("latency", cyc - last_fetch_cyc, 32'd3);
    last_fetch_cyc = cyc;
    addr0 = bus.fetch_addr;
    pc0   = bus.pc;
    for (int i = 0; i < wait_cyc; i++) begin
      if (stray_done && i == 0) begin
        bus.opcode     = OP_BR;
        bus.reg_target = 32'h0000_0100;
        bus.exec_done  = 1'b1;
      end
      tick();
      bus.exec_done = 1'b0;
      check("wait_req", bus.fetch_req, 1'b1);
      check("wait_addr", bus.fetch_addr, addr0);
    end
    if (stray_done) check("stray_done_pc", bus.pc, pc0);
    bus.fetch_ack = 1'b1;
    tick();
    bus.fetch_ack = 1'b0;
    check("enter_exec", dbg_state, ST_EXEC);
    check("req_drop", bus.fetch_req, 1'b0);
  endtask

  task automatic exec_phase(input vec_t v);
    check("link_we_cleared", bus.link_we, 1'b0);
    if (v.stray_halt) bus.halt_req = 1'b1;
    tick();
    bus.halt_req = 1'b0;
    if (v.stray_halt) check("stray_halt_ignored", dbg_state, ST_EXEC);
    bus.opcode     = v.opcode;
    bus.valid_jump = v.vj;
    bus.offset     = v.offset;
    bus.reg_target = v.reg_target;
    bus.halt_req   = v.halt;
    bus.exec_done  = 1'b1;
    tick();
    bus.exec_done  = 1'b0;
    bus.halt_req   = 1'b0;
    bus.valid_jump = 1'b0;
    if (!v.exp_fault) exp_instret++;
    check("pc", bus.pc, v.exp_pc);
    check("instret", bus.instret, exp_instret);
    check("link_we", bus.link_we, v.exp_lw);
    check("link_addr", bus.link_addr, v.exp_la);
    check("fault", bus.fault, v.exp_fault);
    check("halted", bus.halted, v.halt && !v.exp_fault);
    if (!v.exp_fault && !v.halt) exp_q.push_back(v.exp_pc);
  endtask

  task automatic run_vec(input vec_t v, input logic measure);
    fetch_phase(v.wait_cyc, v.stray_done, measure);
    exec_phase(v);
  endtask

  task automatic hold(input int n, input state_t st, input logic [31:0] epc);
    for (int i = 0; i < n; i++) begin
      bus.opcode     = OP_BR;
      bus.reg_target = 32'h0000_0080;
      bus.exec_done  = (i % 3 == 0);
      bus.fetch_ack  = 1'b1;
      tick();
      check("hold_req", bus.fetch_req, 1'b0);
      check("hold_pc", bus.pc, epc);
      check("hold_instret", bus.instret, exp_instret);
    end
    bus.exec_done = 1'b0;
    bus.fetch_ack = 1'b0;
    check("hold_state", dbg_state, st);
  endtask

  initial begin
    bus.fetch_ack  = 1'b0;
    bus.exec_done  = 1'b0;
    bus.opcode     = 6'd0;
    bus.valid_jump = 1'b0;
    bus.offset     = 32'd0;
    bus.reg_target = 32'd0;
    bus.halt_req   = 1'b0;

    //        op        vj off            rt            w  sd sh h  exp_pc        lw la            f
    vecs.push_back(mk(6'b000000, 0, 32'd0,        32'd0,        0, 0, 0, 0, 32'h0000_0004, 0, 32'h0,  0));
    vecs.push_back(mk(6'b000000, 0, 32'd0,        32'd0,        0, 0, 0, 0, 32'h0000_0008, 0, 32'h0,  0));
    vecs.push_back(mk(6'b000000, 0, 32'd0,        32'd0,        0, 0, 0, 0, 32'h0000_000C, 0, 32'h0,  0));
    vecs.push_back(mk(OP_BR,     0, 32'd0,        32'h10,       2, 1, 0, 0, 32'h0000_0010, 0, 32'h0,  0));
    vecs.push_back(mk(OP_B,      1, 32'hFFFF_FFFE, 32'd0,       0, 0, 0, 0, 32'h0000_000C, 0, 32'h0,  0));
    vecs.push_back(mk(OP_BR,     0, 32'd0,        32'h10,       1, 0, 0, 0, 32'h0000_0010, 0, 32'h0,  0));
    vecs.push_back(mk(OP_BZ,     0, 32'd7,        32'd0,        0, 0, 0, 0, 32'h0000_0014, 0, 32'h0,  0));
    vecs.push_back(mk(OP_BR,     0, 32'd0,        32'h40,       5, 0, 0, 0, 32'h0000_0040, 0, 32'h0,  0));
    vecs.push_back(mk(OP_BL,     1, 32'd4,        32'd0,        0, 0, 0, 0, 32'h0000_0054, 1, 32'h44, 0));
    vecs.push_back(mk(OP_BR,     0, 32'd0,        32'h44,       0, 0, 0, 0, 32'h0000_0044, 0, 32'h44, 0));
    vecs.push_back(mk(OP_BL,     0, 32'd9,        32'd0,        0, 0, 0, 0, 32'h0000_0048, 1, 32'h48, 0));
    vecs.push_back(mk(OP_BLTZ,   1, 32'd1,        32'd0,        0, 0, 0, 0, 32'h0000_0050, 0, 32'h48, 0));
    vecs.push_back(mk(6'b000111, 1, 32'd5,        32'd0,        0, 0, 1, 0, 32'h0000_0054, 0, 32'h48, 0));
    vecs.push_back(mk(OP_BR,     0, 32'd0,        32'hFFFF_FFFC, 0, 0, 0, 0, 32'hFFFF_FFFC, 0, 32'h48, 0));
    vecs.push_back(mk(6'b000000, 0, 32'd0,        32'd0,        0, 0, 0, 0, 32'h0000_0000, 0, 32'h48, 0));
    vecs.push_back(mk(OP_BCY,    1, 32'hFFFF_FFFF, 32'd0,       0, 0, 0, 0, 32'h0000_0000, 0, 32'h48, 0));
    vecs.push_back(mk(OP_BNCY,   1, 32'h10,       32'd0,        0, 0, 0, 0, 32'h0000_0044, 0, 32'h48, 0));
    vecs.push_back(mk(OP_BR,     0, 32'd0,        32'h20,       0, 0, 0, 0, 32'h0000_0020, 0, 32'h48, 0));
    vecs.push_back(mk(6'b000000, 0, 32'd0,        32'd0,        0, 0, 0, 1, 32'h0000_0024, 0, 32'h48, 0));

    async_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], (i >= 1 && i <= 3));
    end
    hold(10, ST_HALT, 32'h0000_0024);

    // Misaligned br: pc stays at 0x30, everything frozen until reset.
    #3;
    async_reset();
    run_vec(mk(OP_BR, 0, 32'd0, 32'h30, 0, 0, 0, 0, 32'h0000_0030, 0, 32'h0, 0), 1'b0);
    run_vec(mk(OP_BR, 0, 32'd0, 32'h46, 0, 0, 0, 0, 32'h0000_0030, 0, 32'h0, 1), 1'b0);
    hold(10, ST_FAULT, 32'h0000_0030);
    check("fault_held", bus.fault, 1'b1);
    #3;
    async_reset();

    // Reset while waiting in EXEC abandons the instruction.
    fetch_phase(0, 1'b0, 1'b0);
    #3;
    async_reset();
    run_vec(mk(6'b000000, 0, 32'd0, 32'd0, 0, 0, 0, 0, 32'h0000_0004, 0, 32'h0, 0), 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
